// File: rtl/rot_pkg.sv
// Shared types and sizes for the rotate scheduler.
package rot_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned AMT_W        = 3;
  localparam int unsigned STEP_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shifter.sv
// 8-bit right-rotator by 0..3 positions.
module shifter
  import rot_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = in;
    case (shift)
      2'd1:    out = {in[0],   in[7:1]};
      2'd2:    out = {in[1:0], in[7:2]};
      2'd3:    out = {in[2:0], in[7:3]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/rot_sched.sv
// Two-requester round-robin scheduler that right-rotates an operand in
// steps of at most STEP_MAX positions per cycle.
module rot_sched
  import rot_pkg::*;
#(
  parameter int unsigned STEP_MAX = STEP_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d, rot_out;
  logic [AMT_W-1:0]    rem_q, rem_d, amt_sel;
  logic                id_q, id_d, ptr_q, ptr_d;
  logic                res_valid_d, busy_d;
  logic                grant0, grant1;
  logic [1:0]          step;

  // ptr_q holds the id served last; the other requester wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ptr_q;
        grant1 = !ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign amt_sel    = grant1 ? req1_amt : req0_amt;

  always_comb begin
    if (rem_q > AMT_W'(STEP_MAX)) step = 2'(STEP_MAX);
    else                          step = rem_q[1:0];
  end

  shifter u_shifter (
    .in    (data_q),
    .shift (step),
    .out   (rot_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          data_d  = grant1 ? req1_data : req0_data;
          rem_d   = amt_sel;
          id_d    = grant1;
          ptr_d   = grant1;
          state_d = (amt_sel == '0) ? DONE : ROT;
        end
      end
      ROT: begin
        data_d = rot_out;
        rem_d  = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      rem_q     <= '0;
      id_q      <= 1'b0;
      ptr_q     <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      res_valid <= res_valid_d;
      busy      <= busy_d;
    end
  end

  // Result registers double as the working registers; only DONE exposes them.
  assign res_data = data_q;
  assign res_id   = id_q;

endmodule

// File: tb/tb_rot_sched.sv
// Scoreboard bench for rot_sched: directed scenarios plus random traffic.
module tb_rot_sched;

  localparam int unsigned STEP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic [2:0] req0_amt = 3'd0, req1_amt = 3'd0;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_id, busy;

  rot_sched #(.STEP_MAX(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: rotate right by amt, one bit at a time.
  function automatic logic [7:0] rotr(input logic [7:0] d, input int a);
    logic [7:0] r;
    r = d;
    for (int k = 0; k < a; k++) r = {r[0], r[7:1]};
    return r;
  endfunction

  function automatic int lat_of(input int a);
    return (a + STEP - 1) / STEP + 1;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       id;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  bit   m_busy = 1'b0;
  bit   m_last = 1'b1;
  int   m_cnt  = 0;

  // Monitor: model of grants, latency and result contents, sampled mid-cycle.
  always @(negedge clk) begin
    bit e0, e1, ev;
    if (!rst_n) begin
      chk("ready0_rst", 32'(req0_ready), 0);
      chk("ready1_rst", 32'(req1_ready), 0);
      sbq.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      e0 = 1'b0; e1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin e0 = m_last; e1 = !m_last; end
        else begin e0 = req0_valid; e1 = req1_valid; end
      end
      chk("ready0", 32'(req0_ready), 32'(e0));
      chk("ready1", 32'(req1_ready), 32'(e1));
      chk("busy", 32'(busy), 32'(m_busy));
      if (m_busy && sbq.size() > 0) begin
        m_cnt++;
        ev = (m_cnt >= sbq[0].lat);
        chk("res_valid", 32'(res_valid), 32'(ev));
        if (ev) begin
          chk("res_data", 32'(res_data), 32'(sbq[0].d));
          chk("res_id", 32'(res_id), 32'(sbq[0].id));
          if (res_ready) begin
            void'(sbq.pop_front());
            m_busy = 1'b0;
          end
        end
      end else begin
        chk("res_valid_idle", 32'(res_valid), 0);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          exp_t e;
          e.id  = req1_ready;
          e.d   = req1_ready ? rotr(req1_data, int'(req1_amt)) : rotr(req0_data, int'(req0_amt));
          e.lat = req1_ready ? lat_of(int'(req1_amt)) : lat_of(int'(req0_amt));
          sbq.push_back(e);
          m_busy = 1'b1;
          m_cnt  = 0;
          m_last = e.id;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one op, wait for its result and check it against fixed values.
  task automatic op(input bit id, input logic [7:0] d, input logic [2:0] a,
                    input logic [7:0] ed, input int elat, input string nm);
    bit ok;
    int n;
    ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; req1_amt = a; end
    else    begin req0_valid = 1'b1; req0_data = d; req0_amt = a; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    chk({nm, "_accept"}, 32'(ok), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'($urandom); req1_data = 8'($urandom);
    req0_amt  = 3'($urandom); req1_amt  = 3'($urandom);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (res_valid) begin ok = 1'b1; break; end
    end
    chk({nm, "_done"}, 32'(ok), 1);
    chk({nm, "_lat"}, 32'(n), 32'(elat));
    chk({nm, "_data"}, 32'(res_data), 32'(ed));
    chk({nm, "_id"}, 32'(res_id), 32'(id));
  endtask

  initial begin
    int grants[$];
    bit ok;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    tick();

    res_ready = 1'b1;
    op(1'b0, 8'hB4, 3'd5, 8'hA5, 3, "r0_b4_amt5");
    tick();
    op(1'b1, 8'h3C, 3'd0, 8'h3C, 1, "r1_3c_amt0");
    tick();
    op(1'b0, 8'h01, 3'd7, 8'h02, 4, "r0_01_amt7");
    tick();

    // Held tie after reset alternates starting with req0.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_amt = 3'd1; req1_amt = 3'd1;
    req0_data = 8'h5A; req1_data = 8'hC3;
    for (int i = 0; i < 80 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
    end
    chk("rr_count", 32'(grants.size()), 4);
    for (int k = 0; k < grants.size(); k++) chk("rr_order", 32'(grants[k]), 32'(k % 2));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Consumer stalls in DONE; req1 pending must not be granted.
    res_ready = 1'b0;
    op(1'b0, 8'h80, 3'd2, 8'h20, 2, "stall");
    tick();
    req1_valid = 1'b1; req1_amt = 3'd0; req1_data = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_data", 32'(res_data), 32'h20);
      chk("stall_hold_valid", 32'(res_valid), 1);
      chk("stall_hold_r1", 32'(req1_ready), 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset mid-rotation abandons the op and re-arms the pointer for req0.
    req0_valid = 1'b1; req0_data = 8'hF0; req0_amt = 3'd7;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready) begin ok = 1'b1; break; end
    end
    chk("abort_accept", 32'(ok), 1);
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_res_valid", 32'(res_valid), 0);
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("abort_tie_r0", 32'(req0_ready), 1);
    chk("abort_tie_r1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Random traffic, checked entirely by the monitor.
    for (int i = 0; i < 1500; i++) begin
      req0_valid = 1'($urandom_range(0, 2) != 0);
      req1_valid = 1'($urandom_range(0, 2) != 0);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      req0_amt   = 3'($urandom);
      req1_amt   = 3'($urandom);
      res_ready  = 1'($urandom_range(0, 3) != 0);
      rst_n      = 1'($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("drain_empty", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rot_sched.md
ROT_SCHED -- requirements
Module: rot_sched

Interface
REQ-001 The block SHALL have one parameter: STEP_MAX, default 3, the maximum rotation applied per pass (legal 1..3).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 req0_data / req1_data  input  8  operand.
REQ-008 req0_amt / req1_amt  input  3  right-rotate amount, 0..7.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 res_data  output  8  rotated operand.
REQ-012 res_id  output  1  requester that owns the result (0 or 1).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Operation: res_data SHALL equal req_data rotated right by req_amt, i.e. bit i = in[(i+amt) mod 8].
REQ-015 The FSM SHALL have three states: IDLE, ROT and DONE.
REQ-016 In IDLE the arbiter SHALL assert exactly one reqN_ready, combinationally, for one valid requester.
- Only one valid: grant it.
- Both valid: grant the requester not served last (round-robin pointer).
REQ-017 On acceptance (valid && ready) the block SHALL latch the data, amount and id, and the pointer SHALL record the served id.
- If amt == 0: go to DONE.
- Otherwise: go to ROT.
REQ-018 Each ROT cycle SHALL apply step = min(rem, STEP_MAX) through the rotator, then set rem -= step.
- Go to DONE when the new rem == 0.
REQ-019 Latency from acceptance edge to res_valid high SHALL be ceil(amt/STEP_MAX)+1 cycles.
- amt 0: 1 cycle.
- amt 7 with STEP_MAX=3: 4 cycles.
REQ-020 In DONE, res_valid SHALL be 1, and res_data/res_id SHALL hold stable until res_ready is sampled high.
- Then go to IDLE.
REQ-021 Both reqN_ready SHALL be 0 in ROT and DONE.
- No acceptance occurs in the DONE→IDLE handshake cycle; throughput is at most one operation per (latency+1) cycles.
REQ-022 Input changes on req*_data/amt after acceptance SHALL have no effect on the in-flight operation.
REQ-023 res_ready asserted outside DONE SHALL be ignored.

Reset
REQ-024 On a clk edge with rst_n=0, the block SHALL:
- set state=IDLE and the pointer so that req0 wins the next tie;
- clear res_valid, res_data, res_id and busy to 0;
- zero the internal data/rem registers.
REQ-025 Reset asserted in ROT or DONE SHALL abandon the in-flight operation, with no result emitted.
REQ-026 The reqN_ready outputs SHALL be 0 while rst_n=0.

Structure
REQ-027 Package rot_pkg SHALL hold:
- the FSM state enum (IDLE, ROT, DONE);
- DATA_W=8, AMT_W=3 and STEP_MAX default.
REQ-028 The datapath SHALL be one instance of the team's existing 8-bit 0..3 right-rotator sub-module shifter (in, out, shift[1:0]).
- It is driven from the internal data register and step.
- No other rotation logic is permitted.
REQ-029 Arbitration SHALL be implemented inline as one always block plus a 1-bit pointer; no separate arbiter module.

Verification
REQ-030 req0 data=0xB4, amt=5 → 2 ROT cycles (3 then 2) → res_data=0xA5, res_id=0, res_valid 3 cycles after acceptance.
REQ-031 req1 data=0x3C, amt=0 → no ROT → res_data=0x3C, res_id=1, res_valid 1 cycle after acceptance.
REQ-032 req0 data=0x01, amt=7 → 3 ROT cycles → res_data=0x02.
REQ-033 Both valid after reset, held (amt=1, res_ready=1):
- grant order SHALL be req0, req1, req0, req1;
- req1 held valid SHALL see ready=0 while req0 is in service.
REQ-034 res_ready low for 4 cycles in DONE (0x80, amt=2) → res_data=0x20 stable, res_valid held, both ready=0; completes on the first cycle res_ready=1.
REQ-035 rst_n=0 for one cycle during ROT (amt=7) → next cycle IDLE, busy=0, res_valid=0, no result emitted; the next tie grants req0.
